// File: rtl/timebase_ctrl.sv
// ============================================================================
//  Module      : timebase_ctrl
//  Description : Shared timebase scheduler. One controllable prescaler driven
//                by an IDLE/RUN/PAUSE state machine produces the counter tick;
//                free-running dividers produce the display scan strobe and
//                the set-mode blink level.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timebase_ctrl #(
  parameter int unsigned CLK_HZ  = 100000000,
  parameter int unsigned TICK_HZ = 1,
  parameter int unsigned FAST_HZ = 8,
  parameter int unsigned SCAN_HZ = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run_cmd,
  input  logic       stop_cmd,
  input  logic       step_cmd,
  input  logic       clr_cmd,
  input  logic       fast_en,
  output logic       tick,
  output logic       scan_tick,
  output logic       blink,
  output logic [1:0] state
);

  localparam int unsigned c_div_n = CLK_HZ / TICK_HZ;
  localparam int unsigned c_div_f = CLK_HZ / FAST_HZ;
  localparam int unsigned c_div_s = CLK_HZ / SCAN_HZ;

  localparam logic [31:0] c_lim_n     = 32'(c_div_n - 1);
  localparam logic [31:0] c_lim_f     = 32'(c_div_f - 1);
  localparam logic [31:0] c_lim_s     = 32'(c_div_s - 1);
  localparam logic [31:0] c_lim_blink = 32'((CLK_HZ / 2) - 1);

  localparam logic [1:0] c_st_idle  = 2'b00;
  localparam logic [1:0] c_st_run   = 2'b01;
  localparam logic [1:0] c_st_pause = 2'b10;

  // Reject dividers that are fractional or too small to produce a strobe.
  generate
    if ((CLK_HZ % TICK_HZ) != 0 || (CLK_HZ % FAST_HZ) != 0 ||
        (CLK_HZ % SCAN_HZ) != 0 || c_div_n < 2 || c_div_f < 2 ||
        c_div_s < 2) begin : g_bad_params
      $error("timebase_ctrl: every divider must be an integer >= 2");
    end
  endgenerate

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [31:0] r_pre_cnt;
  logic [31:0] w_pre_nxt;
  logic        r_tick;
  logic        w_tick_nxt;
  logic [31:0] w_lim;
  logic [31:0] r_scan_cnt;
  logic        r_scan_tick;
  logic [31:0] r_blink_cnt;
  logic        r_blink;

  assign w_lim = fast_en ? c_lim_f : c_lim_n;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: clear wins everywhere; stop only matters while running.
  always_comb begin
    w_state_nxt = r_state;
    if (clr_cmd) begin
      w_state_nxt = c_st_idle;
    end else begin
      case (r_state)
        c_st_run: begin
          if (stop_cmd) w_state_nxt = c_st_pause;
        end
        c_st_pause: begin
          if (run_cmd) w_state_nxt = c_st_run;
        end
        default: begin
          // IDLE and the unused code both behave as IDLE.
          w_state_nxt = run_cmd ? c_st_run : c_st_idle;
        end
      endcase
    end
  end

  // Prescaler and tick next values: count in RUN, step outside RUN.
  always_comb begin
    w_pre_nxt  = r_pre_cnt;
    w_tick_nxt = 1'b0;
    if (clr_cmd) begin
      w_pre_nxt = '0;
    end else if (r_state == c_st_run) begin
      // A stop in the terminal cycle freezes the count at LIM, so the
      // suppressed tick fires on the first edge after resuming.
      if (!stop_cmd) begin
        if (r_pre_cnt >= w_lim) begin
          w_pre_nxt  = '0;
          w_tick_nxt = 1'b1;
        end else begin
          w_pre_nxt = r_pre_cnt + 32'd1;
        end
      end
    end else if (!run_cmd && step_cmd) begin
      w_pre_nxt  = '0;
      w_tick_nxt = 1'b1;
    end
  end

  // Prescaler and tick registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre_cnt <= '0;
      r_tick    <= 1'b0;
    end else begin
      r_pre_cnt <= w_pre_nxt;
      r_tick    <= w_tick_nxt;
    end
  end

  // Free-running scan divider, deliberately blind to the commands.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scan_cnt  <= '0;
      r_scan_tick <= 1'b0;
    end else begin
      r_scan_tick <= (r_scan_cnt == c_lim_s);
      r_scan_cnt  <= (r_scan_cnt == c_lim_s) ? '0 : r_scan_cnt + 32'd1;
    end
  end

  // Free-running half-second divider toggling the blink level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (r_blink_cnt == c_lim_blink) begin
      r_blink_cnt <= '0;
      r_blink     <= ~r_blink;
    end else begin
      r_blink_cnt <= r_blink_cnt + 32'd1;
    end
  end

  assign tick      = r_tick;
  assign scan_tick = r_scan_tick;
  assign blink     = r_blink;
  assign state     = r_state;

endmodule

`default_nettype wire

// File: tb/tb_timebase_ctrl.sv
// ============================================================================
//  Module      : tb_timebase_ctrl
//  Description : Self-checking bench for timebase_ctrl. A cycle model pushes
//                expected outputs to a scoreboard each cycle; a table of
//                command rows checks end state, tick counts and first-tick
//                offsets; a hand sequence covers reset in the middle of RUN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timebase_ctrl;

  localparam int c_lim_n = 99;   // DIV_N - 1
  localparam int c_lim_f = 24;   // DIV_F - 1
  localparam int c_lim_s = 9;    // DIV_S - 1
  localparam int c_lim_b = 49;   // CLK_HZ/2 - 1

  logic       clk = 1'b0;
  logic       reset, run_cmd, stop_cmd, step_cmd, clr_cmd, fast_en;
  logic       tick, scan_tick, blink;
  logic [1:0] state;

  timebase_ctrl #(
    .CLK_HZ (100),
    .TICK_HZ(1),
    .FAST_HZ(4),
    .SCAN_HZ(10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .run_cmd  (run_cmd),
    .stop_cmd (stop_cmd),
    .step_cmd (step_cmd),
    .clr_cmd  (clr_cmd),
    .fast_en  (fast_en),
    .tick     (tick),
    .scan_tick(scan_tick),
    .blink    (blink),
    .state    (state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_no  = 0;

  // Reference model state.
  logic [1:0] m_state = 2'b00;
  int         m_pre   = 0;
  logic       m_tick  = 1'b0;
  int         m_scan  = 0;
  logic       m_stick = 1'b0;
  int         m_bcnt  = 0;
  logic       m_blink = 1'b0;

  logic [4:0] sb_q[$];

  // Per-row measurements taken from the DUT outputs.
  int   row_off, row_ticks, row_first, row_scans, row_blinks;
  logic row_prev_blink;

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic cyc(input logic i_rst, input logic i_run, input logic i_stop,
                     input logic i_step, input logic i_clr, input logic i_fast);
    logic [4:0] exp_v;
    logic [4:0] got_v;
    reset    = i_rst;
    run_cmd  = i_run;
    stop_cmd = i_stop;
    step_cmd = i_step;
    clr_cmd  = i_clr;
    fast_en  = i_fast;
    if (i_rst) begin
      m_state = 2'b00; m_pre = 0; m_tick = 1'b0;
      m_scan = 0; m_stick = 1'b0; m_bcnt = 0; m_blink = 1'b0;
    end else begin
      m_tick = 1'b0;
      if (i_clr) begin
        m_state = 2'b00;
        m_pre   = 0;
      end else if (m_state == 2'b01) begin
        if (i_stop) m_state = 2'b10;
        else if (m_pre >= (i_fast ? c_lim_f : c_lim_n)) begin
          m_pre  = 0;
          m_tick = 1'b1;
        end else m_pre = m_pre + 1;
      end else if (i_run) begin
        m_state = 2'b01;
      end else if (i_step) begin
        m_pre  = 0;
        m_tick = 1'b1;
      end
      m_stick = (m_scan == c_lim_s);
      m_scan  = (m_scan == c_lim_s) ? 0 : m_scan + 1;
      if (m_bcnt == c_lim_b) begin
        m_bcnt  = 0;
        m_blink = ~m_blink;
      end else m_bcnt = m_bcnt + 1;
    end
    sb_q.push_back({m_state, m_tick, m_stick, m_blink});
    @(posedge clk);
    #1;
    cyc_no++;
    got_v = {state, tick, scan_tick, blink};
    exp_v = sb_q.pop_front();
    n_tests++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL cycle %0d {state,tick,scan_tick,blink}: got %b, expected %b",
               cyc_no, got_v, exp_v);
    end
    if (tick === 1'b1) begin
      row_ticks++;
      if (row_first < 0) row_first = row_off;
    end
    if (scan_tick === 1'b1) row_scans++;
    if (blink !== row_prev_blink) row_blinks++;
    row_prev_blink = blink;
    row_off++;
  endtask

  task automatic row_start();
    row_off = 0; row_ticks = 0; row_first = -1; row_scans = 0; row_blinks = 0;
    row_prev_blink = blink;
  endtask

  typedef struct {
    logic run, stop, step, clr, fast;
    int   hold;     // idle cycles after the command cycle
    int   st;       // expected state at the end of the row
    int   ticks;    // ticks seen in the row
    int   first;    // offset of first tick from the command edge, -1 none
    int   scans;    // scan strobes in the row, -1 don't care
    int   blinks;   // blink toggles in the row, -1 don't care
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  initial begin
    int n_scan_edge;
    int n_blink_edge;

    //            run   stop  step  clr   fast  hold st tk first scan blnk
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 299, 0, 0, -1, 30, 6};  // idle 300
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 300, 1, 3, 100, -1, -1}; // run
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 39,  1, 0, -1, -1, -1};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 499, 2, 0, -1, -1, -1}; // stop 40 after tick
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 99,  1, 1, 60, -1, -1}; // resume
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20,  1, 0, -1, -1, -1}; // pre -> 60
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 99,  1, 4, 0,  -1, -1}; // fast
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 199, 1, 2, 75, -1, -1}; // back to normal
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9,   2, 0, -1, -1, -1}; // pause
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9,   2, 1, 0,  -1, -1}; // step
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 105, 1, 1, 100, -1, -1}; // step+run
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 9,   0, 0, -1, -1, -1}; // clr+stop
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 100, 1, 1, 100, -1, -1}; // run from clr
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9,   1, 0, -1, -1, -1}; // step ignored
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 88,  1, 0, -1, -1, -1}; // run ignored
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4,   2, 0, -1, -1, -1}; // stop at LIM
    vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4,   1, 1, 1,  -1, -1}; // held tick fires

    row_start();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset state", int'(state), 0);
    chk("reset tick", int'(tick), 0);
    chk("reset scan_tick", int'(scan_tick), 0);
    chk("reset blink", int'(blink), 0);

    for (int i = 0; i < NV; i++) begin
      row_start();
      cyc(1'b0, vecs[i].run, vecs[i].stop, vecs[i].step, vecs[i].clr, vecs[i].fast);
      for (int k = 0; k < vecs[i].hold; k++)
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, vecs[i].fast);
      chk($sformatf("row%0d state", i), int'(state), vecs[i].st);
      chk($sformatf("row%0d tick count", i), row_ticks, vecs[i].ticks);
      chk($sformatf("row%0d first tick offset", i), row_first, vecs[i].first);
      if (vecs[i].scans >= 0)
        chk($sformatf("row%0d scan count", i), row_scans, vecs[i].scans);
      if (vecs[i].blinks >= 0)
        chk($sformatf("row%0d blink toggles", i), row_blinks, vecs[i].blinks);
    end

    // Reset while running, with a run command also asserted: reset wins.
    row_start();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("midrun reset state", int'(state), 0);
    chk("midrun reset tick", int'(tick), 0);
    chk("midrun reset scan_tick", int'(scan_tick), 0);
    chk("midrun reset blink", int'(blink), 0);
    n_scan_edge  = -1;
    n_blink_edge = -1;
    for (int k = 1; k <= 200 && n_blink_edge < 0; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (scan_tick === 1'b1 && n_scan_edge < 0) n_scan_edge = k;
      if (blink === 1'b1 && n_blink_edge < 0) n_blink_edge = k;
    end
    chk("scan restart edges", n_scan_edge, 10);
    chk("blink restart edges", n_blink_edge, 50);
    chk("no tick after reset", row_ticks, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
